bsr_chain: RTL and testbench

BSR_CHAIN -- requirements
Module: bsr_chain

---
 rtl/bsr_chain.sv | 150 +++++++++++++++
 tb/tb_bsr_chain.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_chain.sv
// bsr_chain: boundary-scan register chain of CHANNELS channels, WIDTH bits each.
// Each channel has a shift register and an update register. With the optional
// macro BSR_SEGMENT_SELECT_EN defined, each channel also has a bypass flop, and a
// selection mask decides whether that channel's shift register or its bypass flop
// sits in the scan path. Without the macro every channel is always in the path.
module bsr_chain #(
    parameter int CHANNELS = 6,
    parameter int WIDTH    = 32
) (
    input  logic                      tck,
    input  logic                      trst,
    input  logic                      tdi,
    output logic                      tdo,
    input  logic                      capture_dr,
    input  logic                      shift_dr,
    input  logic                      update_dr,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       seg_sel,
    input  logic                      seg_load,
    input  logic [CHANNELS*WIDTH-1:0] parallel_in,
    output logic [CHANNELS*WIDTH-1:0] parallel_out
);

    logic [CHANNELS*WIDTH-1:0] sr_q, sr_d;
    logic [CHANNELS*WIDTH-1:0] ur_q, ur_d;
    logic [CHANNELS-1:0]       sel;
    logic [CHANNELS-1:0]       chain_in;
    logic [CHANNELS-1:0]       chain_out;

`ifdef BSR_SEGMENT_SELECT_EN
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CHANNELS-1:0] bp_q, bp_d;

    // Load a new mask only outside shifting so the chain length never changes mid-shift.
    always_comb begin
        mask_d = mask_q;
        if (seg_load && !shift_dr) begin
            mask_d = seg_sel;
        end
    end

    // Bypass flops capture 0 and shift only for deselected channels.
    always_comb begin
        bp_d = bp_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!mask_q[k]) begin
                if (capture_dr) begin
                    bp_d[k] = 1'b0;
                end else if (shift_dr) begin
                    bp_d[k] = chain_in[k];
                end
            end
        end
    end

    // Mask resets to all channels selected; bypass flops reset to 0.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            mask_q <= '1;
            bp_q   <= '0;
        end else begin
            mask_q <= mask_d;
            bp_q   <= bp_d;
        end
    end

    assign sel = mask_q;
`else
    logic unused_seg;

    assign sel        = '1;
    assign unused_seg = ^{seg_sel, seg_load};
`endif

    // Scan output of each channel: SR bit 0 when selected, else its bypass flop.
    always_comb begin
        chain_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef BSR_SEGMENT_SELECT_EN
            chain_out[k] = sel[k] ? sr_q[k*WIDTH] : bp_q[k];
`else
            chain_out[k] = sr_q[k*WIDTH];
`endif
        end
    end

    // Scan input of each channel: tdi for channel 0, previous channel's output otherwise.
    always_comb begin
        chain_in = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (k == 0) begin
                chain_in[k] = tdi;
            end else begin
                chain_in[k] = chain_out[k-1];
            end
        end
    end

    // Shift registers of selected channels capture or shift; capture wins over shift.
    always_comb begin
        logic [WIDTH-1:0] shifted;
        sr_d    = sr_q;
        shifted = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            shifted            = sr_q[k*WIDTH +: WIDTH] >> 1;
            shifted[WIDTH-1]   = chain_in[k];
            if (sel[k]) begin
                if (capture_dr) begin
                    sr_d[k*WIDTH +: WIDTH] = parallel_in[k*WIDTH +: WIDTH];
                end else if (shift_dr) begin
                    sr_d[k*WIDTH +: WIDTH] = shifted;
                end
            end
        end
    end

    // Update registers of selected channels take the pre-edge shift register value.
    always_comb begin
        ur_d = ur_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel[k] && update_dr) begin
                ur_d[k*WIDTH +: WIDTH] = sr_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Scan and update state; reset discards any partial shift and clears the outputs.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr_q <= '0;
            ur_q <= '0;
        end else begin
            sr_q <= sr_d;
            ur_q <= ur_d;
        end
    end

    // Per-channel output mux: functional pass-through or update register in test mode.
    always_comb begin
        parallel_out = parallel_in;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mode[k]) begin
                parallel_out[k*WIDTH +: WIDTH] = ur_q[k*WIDTH +: WIDTH];
            end
        end
    end

    assign tdo = chain_out[CHANNELS-1];

endmodule

// File: tb/tb_bsr_chain.sv
// tb_bsr_chain: directed self-checking bench for bsr_chain with CHANNELS=3, WIDTH=8.
// Build with BSR_SEGMENT_SELECT_EN defined to exercise segment selection.
module tb_bsr_chain;

    localparam int CH = 3;
    localparam int W  = 8;

    logic            tck;
    logic            trst;
    logic            tdi;
    logic            tdo;
    logic            capture_dr;
    logic            shift_dr;
    logic            update_dr;
    logic [CH-1:0]   mode;
    logic [CH-1:0]   seg_sel;
    logic            seg_load;
    logic [CH*W-1:0] parallel_in;
    logic [CH*W-1:0] parallel_out;

    int checks;
    int errors;

    bsr_chain #(.CHANNELS(CH), .WIDTH(W)) dut (
        .tck          (tck),
        .trst         (trst),
        .tdi          (tdi),
        .tdo          (tdo),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .mode         (mode),
        .seg_sel      (seg_sel),
        .seg_load     (seg_load),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Scan order seen at tdo: channel 2 leaves first, then 1, then 0, each LSB first.
    function automatic logic [23:0] chain_view(input logic [23:0] slices);
        chain_view = {slices[7:0], slices[15:8], slices[23:16]};
    endfunction

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_capture();
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
    endtask

    task automatic do_update();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    // Shift 24 bits: din[i] goes in on shift i, dout[i] is tdo seen before shift i.
    task automatic shift_word(input logic [23:0] din, output logic [23:0] dout);
        dout = '0;
        shift_dr = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tdi     = din[i];
            dout[i] = tdo;
            tick();
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
    endtask

    // Capture zeros, inject a single 1 and count shifts until it reaches tdo.
    task automatic measure_length(output int len);
        parallel_in = '0;
        do_capture();
        shift_dr = 1'b1;
        tdi      = 1'b1;
        tick();
        len = 1;
        tdi = 1'b0;
        while (tdo !== 1'b1 && len < 64) begin
            tick();
            len++;
        end
        shift_dr = 1'b0;
        if (tdo !== 1'b1) len = -1;
    endtask

    task automatic test_reset();
        logic [23:0] dout;
        int len;
        trst = 1'b0;
        mode = 3'b111;
        #12;
        checks++;
        if (parallel_out !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_pout got %h want %h", parallel_out, 24'h0);
        end
        checks++;
        if (tdo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_tdo got %b want 0", tdo);
        end
        @(posedge tck);
        #1;
        trst = 1'b1;
        parallel_in = 24'hFFFFFF;
        do_capture();
        do_update();
        checks++;
        if (parallel_out !== 24'hFFFFFF) begin
            errors++;
            $display("[TB] FAIL preload_ur got %h want %h", parallel_out, 24'hFFFFFF);
        end
        shift_dr = 1'b1;
        tdi      = 1'b1;
        repeat (5) tick();
        #2;
        trst = 1'b0;
        #1;
        checks++;
        if (parallel_out !== 24'h0) begin
            errors++;
            $display("[TB] FAIL midshift_reset_pout got %h want %h", parallel_out, 24'h0);
        end
        checks++;
        if (tdo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midshift_reset_tdo got %b want 0", tdo);
        end
        shift_dr = 1'b0;
        tdi      = 1'b0;
        @(posedge tck);
        #1;
        trst = 1'b1;
        shift_word(24'h0, dout);
        checks++;
        if (dout !== 24'h0) begin
            errors++;
            $display("[TB] FAIL sr_cleared got %h want %h", dout, 24'h0);
        end
        checks++;
        if (parallel_out !== 24'h0) begin
            errors++;
            $display("[TB] FAIL ur_stays_zero got %h want %h", parallel_out, 24'h0);
        end
        measure_length(len);
        checks++;
        if (len !== 24) begin
            errors++;
            $display("[TB] FAIL reset_mask_len got %0d want 24", len);
        end
    endtask

    task automatic test_capture_shift();
        logic [23:0] dout;
        mode        = 3'b000;
        parallel_in = 24'h332211;
        #1;
        checks++;
        if (parallel_out !== 24'h332211) begin
            errors++;
            $display("[TB] FAIL functional_pout got %h want %h", parallel_out, 24'h332211);
        end
        do_capture();
        shift_word(24'h0, dout);
        checks++;
        if (dout !== chain_view(24'h332211)) begin
            errors++;
            $display("[TB] FAIL capture_shift_out got %h want %h", dout, chain_view(24'h332211));
        end
    endtask

    task automatic test_shift_update();
        logic [23:0] dout;
        shift_word(chain_view(24'hC3B2A1), dout);
        checks++;
        if (dout !== 24'h0) begin
            errors++;
            $display("[TB] FAIL shift_in_flush got %h want %h", dout, 24'h0);
        end
        do_update();
        mode = 3'b111;
        #1;
        checks++;
        if (parallel_out !== 24'hC3B2A1) begin
            errors++;
            $display("[TB] FAIL update_pout got %h want %h", parallel_out, 24'hC3B2A1);
        end
        mode        = 3'b010;
        parallel_in = 24'h0FE05D;
        #1;
        checks++;
        if (parallel_out !== 24'h0FB25D) begin
            errors++;
            $display("[TB] FAIL mixed_mode_pout got %h want %h", parallel_out, 24'h0FB25D);
        end
    endtask

    task automatic test_simultaneous();
        logic [23:0] dout;
        int len;
        parallel_in = 24'h9C4E71;
        capture_dr  = 1'b1;
        shift_dr    = 1'b1;
        tdi         = 1'b1;
        tick();
        capture_dr  = 1'b0;
        shift_dr    = 1'b0;
        tdi         = 1'b0;
        shift_word(24'h0, dout);
        checks++;
        if (dout !== chain_view(24'h9C4E71)) begin
            errors++;
            $display("[TB] FAIL capture_priority got %h want %h", dout, chain_view(24'h9C4E71));
        end
        parallel_in = 24'h332211;
        do_capture();
        shift_dr  = 1'b1;
        update_dr = 1'b1;
        tdi       = 1'b0;
        tick();
        shift_dr  = 1'b0;
        update_dr = 1'b0;
        mode      = 3'b111;
        #1;
        checks++;
        if (parallel_out !== 24'h332211) begin
            errors++;
            $display("[TB] FAIL update_pre_edge got %h want %h", parallel_out, 24'h332211);
        end
        shift_word(24'h0, dout);
        checks++;
        if (dout !== 24'h089119) begin
            errors++;
            $display("[TB] FAIL shift_with_update got %h want %h", dout, 24'h089119);
        end
`ifdef BSR_SEGMENT_SELECT_EN
        seg_sel  = 3'b000;
        seg_load = 1'b1;
        shift_dr = 1'b1;
        tick();
        seg_load = 1'b0;
        shift_dr = 1'b0;
`else
        seg_sel  = 3'b000;
        seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
`endif
        measure_length(len);
        checks++;
        if (len !== 24) begin
            errors++;
            $display("[TB] FAIL seg_load_ignored_len got %0d want 24", len);
        end
    endtask

`ifdef BSR_SEGMENT_SELECT_EN
    task automatic test_segment_select();
        logic [23:0] dout;
        int len;
        seg_sel  = 3'b101;
        seg_load = 1'b1;
        tick();
        seg_load = 1'b0;
        measure_length(len);
        checks++;
        if (len !== 17) begin
            errors++;
            $display("[TB] FAIL seg_len got %0d want 17", len);
        end
        parallel_in = 24'h5A773C;
        do_capture();
        shift_word(24'h0, dout);
        checks++;
        if (dout[16:0] !== {8'h3C, 1'b0, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL seg_shift_out got %h want %h", dout[16:0], {8'h3C, 1'b0, 8'h5A});
        end
        parallel_in = 24'h5A773C;
        do_capture();
        do_update();
        mode = 3'b111;
        #1;
        checks++;
        if (parallel_out !== 24'h5A223C) begin
            errors++;
            $display("[TB] FAIL seg_update_pout got %h want %h", parallel_out, 24'h5A223C);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        trst        = 1'b0;
        tdi         = 1'b0;
        capture_dr  = 1'b0;
        shift_dr    = 1'b0;
        update_dr   = 1'b0;
        mode        = '0;
        seg_sel     = '0;
        seg_load    = 1'b0;
        parallel_in = '0;
        test_reset();
        test_capture_shift();
        test_shift_update();
        test_simultaneous();
`ifdef BSR_SEGMENT_SELECT_EN
        test_segment_select();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
